// File: rtl/fp_special_pkg.sv
// rtl/fp_special_pkg.sv - operand classes and canonical special-value constants
package fp_special_pkg;

  typedef enum logic [2:0] {
    FP_ZERO      = 3'd0,
    FP_SUBNORMAL = 3'd1,
    FP_NORMAL    = 3'd2,
    FP_INF       = 3'd3,
    FP_QNAN      = 3'd4,
    FP_SNAN      = 3'd5
  } fp_class_e;

  // Constants are built in a wide word; callers truncate to their own width.
  localparam int FP_MAX_W = 64;

  function automatic logic [FP_MAX_W-1:0] fp_canon_inf(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] ones;
    ones = (FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1);
    return ones << man_w;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_canon_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = fp_canon_inf(exp_w, man_w);
    v[man_w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - IEEE-754 operand classifier (sign-independent)
module fp_classify
  import fp_special_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] mag,
  output fp_class_e              cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = mag[MAN_W +: EXP_W];
  assign man_f = mag[MAN_W-1:0];

  always_comb begin
    cls = FP_NORMAL;
    if (exp_f == '0) begin
      cls = (man_f == '0) ? FP_ZERO : FP_SUBNORMAL;
    end else if (&exp_f) begin
      if (man_f == '0)
        cls = FP_INF;
      else if (man_f[MAN_W-1])
        cls = FP_QNAN;
      else
        cls = FP_SNAN;
    end
  end

endmodule

// File: rtl/fp_special_addsub_pipe.sv
// rtl/fp_special_addsub_pipe.sv - 2-stage special-case resolver for FP add/sub
// Optional sticky invalid flag enabled by defining FP_SPECIAL_FLAGS_EN.
module fp_special_addsub_pipe
  import fp_special_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   is_special,
  output logic [2:0]             class_a,
`ifdef FP_SPECIAL_FLAGS_EN
  output logic                   flag_invalid,
  input  logic                   flag_clr,
`endif
  output logic [2:0]             class_b
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN    = W'(fp_canon_qnan(EXP_W, MAN_W));
  localparam logic [W-2:0] INF_MAG = (W-1)'(fp_canon_inf(EXP_W, MAN_W));

  fp_class_e cls_a_in, cls_b_in;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.mag(a[W-2:0]), .cls(cls_a_in));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.mag(b[W-2:0]), .cls(cls_b_in));

  logic           s1_valid;
  fp_class_e      s1_cls_a, s1_cls_b;
  logic [W-1:0]   s1_a;
  logic [W-2:0]   s1_b_mag;
  logic           s1_sb;
  logic           s2_adv, in_fire;

  // Stage 2 frees up when empty or draining; stage 1 may then refill the same cycle.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;

  logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sa;
  logic [W-1:0] res_d;
  logic         special_d;

  assign a_nan  = (s1_cls_a == FP_QNAN) || (s1_cls_a == FP_SNAN);
  assign b_nan  = (s1_cls_b == FP_QNAN) || (s1_cls_b == FP_SNAN);
  assign a_inf  = (s1_cls_a == FP_INF);
  assign b_inf  = (s1_cls_b == FP_INF);
  assign a_zero = (s1_cls_a == FP_ZERO);
  assign b_zero = (s1_cls_b == FP_ZERO);
  assign sa     = s1_a[W-1];

  // Precedence: NaN, then INF, then ZERO; two finite nonzero operands go to the main adder.
  always_comb begin
    res_d     = '0;
    special_d = 1'b1;
    if (a_nan || b_nan)
      res_d = QNAN;
    else if (a_inf && b_inf)
      res_d = (sa != s1_sb) ? QNAN : {sa, INF_MAG};
    else if (a_inf)
      res_d = {sa, INF_MAG};
    else if (b_inf)
      res_d = {s1_sb, INF_MAG};
    else if (a_zero && b_zero)
      res_d = {sa && s1_sb, {(W-1){1'b0}}};
    else if (a_zero)
      res_d = {s1_sb, s1_b_mag};
    else if (b_zero)
      res_d = s1_a;
    else
      special_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_cls_a   <= FP_ZERO;
      s1_cls_b   <= FP_ZERO;
      s1_a       <= '0;
      s1_b_mag   <= '0;
      s1_sb      <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
      is_special <= 1'b0;
      class_a    <= FP_ZERO;
      class_b    <= FP_ZERO;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_cls_a <= cls_a_in;
        s1_cls_b <= cls_b_in;
        s1_a     <= a;
        s1_b_mag <= b[W-2:0];
        s1_sb    <= b[W-1] ^ op;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          result     <= res_d;
          is_special <= special_d;
          class_a    <= s1_cls_a;
          class_b    <= s1_cls_b;
        end
      end
    end
  end

`ifdef FP_SPECIAL_FLAGS_EN
  logic s2_invalid, invalid_d;

  assign invalid_d = (s1_cls_a == FP_SNAN) || (s1_cls_b == FP_SNAN) ||
                     (a_inf && b_inf && (sa != s1_sb));

  // The flag tracks delivered results only, so it is raised on the output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_invalid   <= 1'b0;
      flag_invalid <= 1'b0;
    end else begin
      if (s2_adv && s1_valid)
        s2_invalid <= invalid_d;
      if (out_valid && out_ready && s2_invalid)
        flag_invalid <= 1'b1;
      else if (flag_clr)
        flag_invalid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fp_special_addsub_pipe.sv
// tb/tb_fp_special_addsub_pipe.sv - randomized self-checking bench for fp_special_addsub_pipe
module tb_fp_special_addsub_pipe;
  import fp_special_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, op, out_valid, out_ready, is_special;
  logic [31:0] a, b, result;
  logic [2:0]  class_a, class_b;
  logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready, h_is_special;
  logic [15:0] h_a, h_b, h_result;
  logic [2:0]  h_class_a, h_class_b;
`ifdef FP_SPECIAL_FLAGS_EN
  logic        flag_invalid, flag_clr, h_flag_invalid, h_flag_clr;
`endif

  fp_special_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .is_special(is_special), .class_a(class_a),
`ifdef FP_SPECIAL_FLAGS_EN
    .flag_invalid(flag_invalid), .flag_clr(flag_clr),
`endif
    .class_b(class_b)
  );

  fp_special_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .op(h_op), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .is_special(h_is_special), .class_a(h_class_a),
`ifdef FP_SPECIAL_FLAGS_EN
    .flag_invalid(h_flag_invalid), .flag_clr(h_flag_clr),
`endif
    .class_b(h_class_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        spec;
    logic [2:0]  ca;
    logic [2:0]  cb;
    logic        inv;
  } exp_t;

  function automatic logic [2:0] cls_of(input logic [31:0] x, input int ew, input int mw);
    logic [31:0] emax, e, m;
    emax = (32'd1 << ew) - 32'd1;
    e    = (x >> mw) & emax;
    m    = x & ((32'd1 << mw) - 32'd1);
    if (e == 0)    return (m == 0) ? FP_ZERO : FP_SUBNORMAL;
    if (e == emax) begin
      if (m == 0) return FP_INF;
      return ((m >> (mw - 1)) & 32'd1) != 0 ? FP_QNAN : FP_SNAN;
    end
    return FP_NORMAL;
  endfunction

  function automatic exp_t model(input logic [31:0] xa, input logic [31:0] xb, input logic xop,
                                 input int ew, input int mw);
    exp_t        r;
    logic [31:0] sbit, mmask, infm, qn;
    logic        sa, sb, an, bn;
    sbit  = 32'd1 << (ew + mw);
    mmask = sbit - 32'd1;
    infm  = ((32'd1 << ew) - 32'd1) << mw;
    qn    = infm | (32'd1 << (mw - 1));
    r.ca  = cls_of(xa, ew, mw);
    r.cb  = cls_of(xb, ew, mw);
    sa    = (xa & sbit) != 0;
    sb    = ((xb & sbit) != 0) ^ xop;
    an    = (r.ca == FP_QNAN) || (r.ca == FP_SNAN);
    bn    = (r.cb == FP_QNAN) || (r.cb == FP_SNAN);
    r.res = 32'd0; r.spec = 1'b1; r.inv = 1'b0;
    if (an || bn) begin
      r.res = qn;
      r.inv = (r.ca == FP_SNAN) || (r.cb == FP_SNAN);
    end else if (r.ca == FP_INF && r.cb == FP_INF) begin
      if (sa != sb) begin r.res = qn; r.inv = 1'b1; end
      else r.res = (sa ? sbit : 32'd0) | infm;
    end else if (r.ca == FP_INF) r.res = (sa ? sbit : 32'd0) | infm;
    else if (r.cb == FP_INF)     r.res = (sb ? sbit : 32'd0) | infm;
    else if (r.ca == FP_ZERO && r.cb == FP_ZERO) r.res = (sa && sb) ? sbit : 32'd0;
    else if (r.ca == FP_ZERO)    r.res = (sb ? sbit : 32'd0) | (xb & mmask);
    else if (r.cb == FP_ZERO)    r.res = xa;
    else r.spec = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] make_op(input int ew, input int mw);
    logic [31:0] emax, e, m, s;
    emax = (32'd1 << ew) - 32'd1;
    s = 32'($urandom_range(0, 1));
    e = 0; m = 0;
    case ($urandom_range(0, 5))
      0: ;
      1: m = 32'($urandom_range(1, (1 << mw) - 1));
      2: begin e = 32'($urandom_range(1, int'(emax) - 1)); m = 32'($urandom_range(0, (1 << mw) - 1)); end
      3: e = emax;
      4: begin e = emax; m = (32'd1 << (mw - 1)) | 32'($urandom_range(0, (1 << (mw - 1)) - 1)); end
      default: begin e = emax; m = 32'($urandom_range(1, (1 << (mw - 1)) - 1)); end
    endcase
    return (s << (ew + mw)) | (e << mw) | m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || is_special !== 1'b0)
      $display("FAIL reset_outputs: got valid=%b result=%h special=%b, want 0/0/0", out_valid, result, is_special);
    else n_pass++;
    n_checks++;
    if (class_a !== 3'(FP_ZERO) || class_b !== 3'(FP_ZERO))
      $display("FAIL reset_classes: got %0d/%0d, want ZERO", class_a, class_b);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] ta [6] = '{32'h3F800000, 32'h7F800000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h3F800000};
    logic [31:0] tb [6] = '{32'h7F800000, 32'h7F800000, 32'h00000000, 32'h00000000, 32'h40400000, 32'h40000000};
    logic        to [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] tr [6] = '{32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h00000000, 32'hC0400000, 32'h00000000};
    logic        ts [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = ta[i]; b = tb[i]; op = to[i]; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      #1;
      while (!out_valid && lat < 10) begin
        @(negedge clk); #1; lat++;
      end
      n_checks++;
      if (lat !== 2) $display("FAIL directed_latency[%0d]: got %0d cycles, want 2", i, lat);
      else n_pass++;
      n_checks++;
      if (result !== tr[i] || is_special !== ts[i])
        $display("FAIL directed_result[%0d]: got %h/%b, want %h/%b", i, result, is_special, tr[i], ts[i]);
      else n_pass++;
`ifdef FP_SPECIAL_FLAGS_EN
      @(negedge clk); #1;
      n_checks++;
      if (flag_invalid !== (i >= 1))
        $display("FAIL directed_flag[%0d]: got %b, want %b", i, flag_invalid, i >= 1);
      else n_pass++;
`endif
    end
`ifdef FP_SPECIAL_FLAGS_EN
    @(negedge clk); flag_clr = 1'b1;
    @(negedge clk); flag_clr = 1'b0; #1;
    n_checks++;
    if (flag_invalid !== 1'b0) $display("FAIL flag_clear: got %b, want 0", flag_invalid);
    else n_pass++;
`endif
  endtask

  task automatic test_random_stream();
    exp_t q[$];
    exp_t e;
    int   budget;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      a = make_op(8, 23); b = make_op(8, 23); op = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_checks++;
      if (in_ready !== ((q.size() < 2) || out_ready))
        $display("FAIL stream_in_ready[%0d]: got %b, want %b", cyc, in_ready, (q.size() < 2) || out_ready);
      else n_pass++;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL stream_spurious[%0d]: got output %h, want none", cyc, result);
        else begin
          e = q.pop_front();
          if ({result, is_special, class_a, class_b} !== {e.res, e.spec, e.ca, e.cb})
            $display("FAIL stream_out[%0d]: got %h/%b/%0d/%0d, want %h/%b/%0d/%0d", cyc,
                     result, is_special, class_a, class_b, e.res, e.spec, e.ca, e.cb);
          else n_pass++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, op, 8, 23));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        n_checks++;
        if ({result, is_special, class_a, class_b} !== {e.res, e.spec, e.ca, e.cb})
          $display("FAIL stream_drain: got %h/%b, want %h/%b", result, is_special, e.res, e.spec);
        else n_pass++;
      end
      @(negedge clk); budget++;
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL stream_lost: got %0d outstanding, want 0", q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia [4], ib [4];
    logic        io [4];
    exp_t q[$];
    int sent = 0, got = 0;
    for (int i = 0; i < 4; i++) begin
      ia[i] = make_op(8, 23); ib[i] = make_op(8, 23); io[i] = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      if (sent < 4) begin a = ia[sent]; b = ib[sent]; op = io[sent]; end
      #1;
      n_checks++;
      if (in_ready !== ((q.size() < 2) || out_ready))
        $display("FAIL b2b_in_ready[%0d]: got %b, want %b", cyc, in_ready, (q.size() < 2) || out_ready);
      else n_pass++;
      if (out_valid) begin
        n_checks++;
        if (q.size() == 0 || result !== q[0].res || is_special !== q[0].spec)
          $display("FAIL b2b_out[%0d]: got %h/%b, want %h/%b", cyc, result, is_special,
                   q.size() ? q[0].res : 32'd0, q.size() ? q[0].spec : 1'b0);
        else n_pass++;
        if (out_ready && q.size() != 0) begin void'(q.pop_front()); got++; end
      end
      if (in_valid && in_ready) begin q.push_back(model(a, b, op, 8, 23)); sent++; end
    end
    in_valid = 1'b0;
    n_checks++;
    if (sent != 4 || got != 4) $display("FAIL b2b_count: got sent=%0d recv=%0d, want 4/4", sent, got);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    bit stale = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = make_op(8, 23); b = make_op(8, 23); op = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0; #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL midreset_full: got valid=%b ready=%b, want 1/0", out_valid, in_ready);
    else n_pass++;
    rst_n = 1'b0; #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midreset_clear: got valid=%b ready=%b, want 0/1", out_valid, in_ready);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    n_checks++;
    if (stale) $display("FAIL midreset_stale: got out_valid after reset, want none");
    else n_pass++;
  endtask

  task automatic test_half_precision();
    exp_t e;
    int   lat;
    h_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      h_a = (i == 0) ? 16'h7C01 : 16'(make_op(5, 10));
      h_b = 16'(make_op(5, 10)); h_op = 1'($urandom_range(0, 1)); h_in_valid = 1'b1;
      e = model({16'd0, h_a}, {16'd0, h_b}, h_op, 5, 10);
      @(negedge clk);
      h_in_valid = 1'b0;
      lat = 1; #1;
      while (!h_out_valid && lat < 10) begin @(negedge clk); #1; lat++; end
      n_checks++;
      if (lat !== 2 || {h_result, h_is_special, h_class_a, h_class_b} !== {e.res[15:0], e.spec, e.ca, e.cb})
        $display("FAIL half[%0d]: got lat=%0d %h/%b/%0d/%0d, want lat=2 %h/%b/%0d/%0d", i, lat,
                 h_result, h_is_special, h_class_a, h_class_b, e.res[15:0], e.spec, e.ca, e.cb);
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (h_result !== 16'h7E00) $display("FAIL half_snan: got %h, want 7e00", h_result);
        else n_pass++;
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    h_in_valid = 1'b0; h_out_ready = 1'b0; h_a = '0; h_b = '0; h_op = 1'b0;
`ifdef FP_SPECIAL_FLAGS_EN
    flag_clr = 1'b0; h_flag_clr = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random_stream();
    test_back_to_back();
    test_reset_midflight();
    test_half_precision();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
